// File: rtl/a8_bus_capture.sv
// A8 bus monitor in the clk200 domain: synchronises the bus, rebuilds PHI2 cycles,
// matches address windows, emits one cycle record per bus cycle and drives extsel/mpd claims.
`timescale 1ns/1ps
module a8_bus_capture #(
  parameter int NUM_WIN     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_DLY    = 8,
  parameter int CLK_TIMEOUT = 255
) (
  input  logic                   clk200,
  input  logic                   rst_n,
  input  logic                   a8_clk,
  input  logic                   a8_rw_n,
  input  logic                   a8_halt_n,
  input  logic                   a8_rst_n,
  input  logic                   a8_ref_n,
  input  logic [15:0]            a8_addr,
  input  logic [7:0]             a8_data,
  input  logic [16*NUM_WIN-1:0]  win_base,
  input  logic [16*NUM_WIN-1:0]  win_mask,
  input  logic [NUM_WIN-1:0]     win_en,
  input  logic [NUM_WIN-1:0]     win_ext,
  output logic                   cyc_valid,
  output logic [15:0]            cyc_addr,
  output logic [7:0]             cyc_data,
  output logic                   cyc_rw_n,
  output logic                   cyc_dma,
  output logic [NUM_WIN-1:0]     cyc_hit,
  output logic [2:0]             cyc_win,
  output logic                   a8_extsel_n,
  output logic                   a8_mpd_n,
  output logic                   clk_lost
);

  // state     | meaning
  // IDLE      | waiting for a PHI2 rise (also forced while clk_lost)
  // WAIT_ADDR | counting down to the address sample point
  // HIGH      | address latched, PHI2 high, claim may be active
  // DONE      | one-cycle record emission after PHI2 fall
  typedef enum logic [1:0] {IDLE, WAIT_ADDR, HIGH, DONE} state_t;

  localparam int SW   = 29;
  localparam int DW   = (ADDR_DLY < 2) ? 1 : $clog2(ADDR_DLY);
  localparam int WTMP = $clog2(CLK_TIMEOUT + 1);
  localparam int WW   = (WTMP > 8) ? WTMP : 8;
  // clk synchroniser resets high so a PHI2 already high at reset release is not a rise
  localparam logic [SW-1:0] SYNC_RST = {5'b11111, 24'h000000};

  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0] bus_s;
  logic          clk_s, rw_s, halt_s, rst_s, ref_s;
  logic [15:0]   addr_s;
  logic [7:0]    data_s;
  logic          clk_d, rise, fall;

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= {a8_clk, a8_rw_n, a8_halt_n, a8_rst_n, a8_ref_n, a8_addr, a8_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign bus_s  = sync_q[SYNC_STAGES-1];
  assign clk_s  = bus_s[28];
  assign rw_s   = bus_s[27];
  assign halt_s = bus_s[26];
  assign rst_s  = bus_s[25];
  assign ref_s  = bus_s[24];
  assign addr_s = bus_s[23:8];
  assign data_s = bus_s[7:0];

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) clk_d <= 1'b1;
    else        clk_d <= clk_s;
  end

  assign rise = clk_s & ~clk_d;
  assign fall = ~clk_s & clk_d;

  logic [NUM_WIN-1:0] hit_raw, hit;
  logic [2:0]         win_lo;
  logic               claim, claim_mpd;

  always_comb begin
    hit_raw = '0;
    for (int i = 0; i < NUM_WIN; i++)
      hit_raw[i] = win_en[i] &
                   (((addr_s ^ win_base[16*i +: 16]) & win_mask[16*i +: 16]) == 16'h0000);
    hit = (ref_s & halt_s & rst_s) ? hit_raw : '0;
    win_lo = 3'd0;
    for (int i = NUM_WIN - 1; i >= 0; i--)
      if (hit[i]) win_lo = 3'(i);
  end

  assign claim     = rw_s & (|(hit & win_ext));
  assign claim_mpd = claim & (addr_s[15:11] == 5'b11011);

  state_t        state, state_nxt;
  logic [DW-1:0] dly_cnt;
  logic          sample;

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    if (clk_lost && !rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (rise) state_nxt = WAIT_ADDR;
        WAIT_ADDR: begin
          if (rise)                 state_nxt = WAIT_ADDR;
          else if (fall)            state_nxt = IDLE;
          else if (dly_cnt == '0) begin
            sample    = 1'b1;
            state_nxt = HIGH;
          end
        end
        HIGH:      if (rise) state_nxt = WAIT_ADDR;
                   else if (fall) state_nxt = DONE;
        DONE:      state_nxt = rise ? WAIT_ADDR : IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n)                                 dly_cnt <= '0;
    else if (rise)                              dly_cnt <= DW'(ADDR_DLY - 1);
    else if (state == WAIT_ADDR && dly_cnt != '0) dly_cnt <= dly_cnt - 1'b1;
  end

  logic [15:0]        lat_addr;
  logic [7:0]         lat_data;
  logic               lat_rw, lat_dma, lat_claim, lat_mpd;
  logic [NUM_WIN-1:0] lat_hit;
  logic [2:0]         lat_win;
  logic               emit, claim_on;

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr  <= '0;
      lat_rw    <= 1'b1;
      lat_dma   <= 1'b0;
      lat_hit   <= '0;
      lat_win   <= '0;
      lat_claim <= 1'b0;
      lat_mpd   <= 1'b0;
    end else if (sample) begin
      lat_addr  <= addr_s;
      lat_rw    <= rw_s;
      lat_dma   <= ~halt_s;
      lat_hit   <= hit;
      lat_win   <= win_lo;
      lat_claim <= claim;
      lat_mpd   <= claim_mpd;
    end
  end

  // tracking every PHI2-high sample leaves the last one in place when the fall is seen
  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n)     lat_data <= '0;
    else if (clk_s) lat_data <= data_s;
  end

  assign emit     = (state == HIGH) && (state_nxt == DONE);
  assign claim_on = (state == HIGH) && (state_nxt == HIGH);

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      cyc_valid <= 1'b0;
      cyc_addr  <= '0;
      cyc_data  <= '0;
      cyc_rw_n  <= 1'b1;
      cyc_dma   <= 1'b0;
      cyc_hit   <= '0;
      cyc_win   <= '0;
    end else begin
      cyc_valid <= emit;
      if (emit) begin
        cyc_addr <= lat_addr;
        cyc_data <= lat_data;
        cyc_rw_n <= lat_rw;
        cyc_dma  <= lat_dma;
        cyc_hit  <= lat_hit;
        cyc_win  <= lat_win;
      end
    end
  end

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      a8_extsel_n <= 1'b1;
      a8_mpd_n    <= 1'b1;
    end else begin
      a8_extsel_n <= ~(claim_on & lat_claim);
      a8_mpd_n    <= ~(claim_on & lat_mpd);
    end
  end

  // watchdog starts saturated so the clock counts as lost until the first rise
  logic [WW-1:0] wd_cnt;

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt   <= WW'(CLK_TIMEOUT);
      clk_lost <= 1'b1;
    end else if (rise) begin
      wd_cnt   <= '0;
      clk_lost <= 1'b0;
    end else if (wd_cnt != WW'(CLK_TIMEOUT)) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WW'(CLK_TIMEOUT - 1)) clk_lost <= 1'b1;
    end
  end

endmodule

// File: tb/tb_a8_bus_capture.sv
// Directed bench for a8_bus_capture: hand-computed records, claim widths,
// boundary high-phase lengths, watchdog timing and mid-cycle reset.
`timescale 1ns/1ps
module tb_a8_bus_capture;

  localparam int NW = 4;
  localparam int HI = 56;
  // raw rise -> sample edge is ADDR_DLY+SYNC+1; claim asserts one later and drops SYNC+1 after fall
  localparam int CLAIM_LEN = HI + 3 - 12;

  logic           clk200 = 1'b0;
  logic           rst_n;
  logic           a8_clk, a8_rw_n, a8_halt_n, a8_rst_n, a8_ref_n;
  logic [15:0]    a8_addr;
  logic [7:0]     a8_data;
  logic [16*NW-1:0] win_base, win_mask;
  logic [NW-1:0]  win_en, win_ext;
  logic           cyc_valid, cyc_rw_n, cyc_dma, a8_extsel_n, a8_mpd_n, clk_lost;
  logic [15:0]    cyc_addr;
  logic [7:0]     cyc_data;
  logic [NW-1:0]  cyc_hit;
  logic [2:0]     cyc_win;

  int checks = 0;
  int errors = 0;
  int n_valid = 0, n_ext = 0, n_mpd = 0;
  int dv, de, dm;

  a8_bus_capture #(.NUM_WIN(NW), .SYNC_STAGES(2), .ADDR_DLY(8), .CLK_TIMEOUT(255)) dut (
    .clk200(clk200), .rst_n(rst_n),
    .a8_clk(a8_clk), .a8_rw_n(a8_rw_n), .a8_halt_n(a8_halt_n), .a8_rst_n(a8_rst_n),
    .a8_ref_n(a8_ref_n), .a8_addr(a8_addr), .a8_data(a8_data),
    .win_base(win_base), .win_mask(win_mask), .win_en(win_en), .win_ext(win_ext),
    .cyc_valid(cyc_valid), .cyc_addr(cyc_addr), .cyc_data(cyc_data), .cyc_rw_n(cyc_rw_n),
    .cyc_dma(cyc_dma), .cyc_hit(cyc_hit), .cyc_win(cyc_win),
    .a8_extsel_n(a8_extsel_n), .a8_mpd_n(a8_mpd_n), .clk_lost(clk_lost)
  );

  always #5 clk200 = ~clk200;

  always @(negedge clk200) begin
    n_valid += int'(cyc_valid);
    n_ext   += int'(!a8_extsel_n);
    n_mpd   += int'(!a8_mpd_n);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_cyc(input logic [15:0] addr, input logic [7:0] d_early, input logic [7:0] d_late,
                         input logic rw, input logic halt, input logic refn, input int hi_len);
    int v0, e0, m0;
    v0 = n_valid; e0 = n_ext; m0 = n_mpd;
    a8_clk = 1'b0; a8_addr = addr; a8_rw_n = rw; a8_halt_n = halt; a8_ref_n = refn;
    repeat (56) @(negedge clk200);
    a8_clk = 1'b1; a8_data = d_early;
    repeat (hi_len - 1) @(negedge clk200);
    a8_data = d_late;
    @(negedge clk200);
    a8_clk = 1'b0;
    repeat (8) @(negedge clk200);
    dv = n_valid - v0; de = n_ext - e0; dm = n_mpd - m0;
  endtask

  initial begin
    int k, v0;
    logic lost_prev;
    rst_n = 1'b0;
    a8_clk = 1'b0; a8_rw_n = 1'b1; a8_halt_n = 1'b1; a8_rst_n = 1'b1; a8_ref_n = 1'b1;
    a8_addr = '0; a8_data = '0;
    win_base = '0; win_mask = '0; win_en = '0; win_ext = '0;
    repeat (4) @(negedge clk200);
    check("rst_valid", cyc_valid, 0);
    check("rst_addr", cyc_addr, 0);
    check("rst_rw", cyc_rw_n, 1);
    check("rst_hit", cyc_hit, 0);
    check("rst_extsel", a8_extsel_n, 1);
    check("rst_mpd", a8_mpd_n, 1);
    check("rst_lost", clk_lost, 1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk200);

    // write $D500, data settles to $5A only in the last PHI2-high cycle
    win_base[15:0] = 16'hD500; win_mask[15:0] = 16'hFF00; win_en = 4'b0001; win_ext = 4'b0000;
    bus_cyc(16'hD500, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b1, HI);
    check("wr_valid", dv, 1);
    check("wr_addr", cyc_addr, 16'hD500);
    check("wr_data", cyc_data, 8'h5A);
    check("wr_rw", cyc_rw_n, 0);
    check("wr_hit", cyc_hit, 4'b0001);
    check("wr_win", cyc_win, 0);
    check("wr_dma", cyc_dma, 0);
    check("wr_ext", de, 0);
    check("wr_lost", clk_lost, 0);

    // claimed read in the $D800 block
    win_base[31:16] = 16'hD800; win_mask[31:16] = 16'hF800; win_en = 4'b0011; win_ext = 4'b0010;
    bus_cyc(16'hD805, 8'h11, 8'h3C, 1'b1, 1'b1, 1'b1, HI);
    check("rd_valid", dv, 1);
    check("rd_hit", cyc_hit, 4'b0010);
    check("rd_win", cyc_win, 1);
    check("rd_data", cyc_data, 8'h3C);
    check("rd_rw", cyc_rw_n, 1);
    check("rd_ext_len", de, CLAIM_LEN);
    check("rd_mpd_len", dm, CLAIM_LEN);

    // overlapping windows; win2 claims outside $D800 so mpd stays high
    win_base[15:0] = 16'hC000; win_mask[15:0] = 16'hFF00;
    win_base[47:32] = 16'hC000; win_mask[47:32] = 16'hF000;
    win_en = 4'b0101; win_ext = 4'b0100;
    bus_cyc(16'hC000, 8'h77, 8'h77, 1'b1, 1'b1, 1'b1, HI);
    check("ov_hit", cyc_hit, 4'b0101);
    check("ov_win", cyc_win, 0);
    check("ov_ext_len", de, CLAIM_LEN);
    check("ov_mpd_len", dm, 0);

    // refresh then DMA on an otherwise claimed window
    win_base[15:0] = 16'hD500; win_mask[15:0] = 16'hFF00; win_en = 4'b0001; win_ext = 4'b0001;
    bus_cyc(16'hD500, 8'h01, 8'h01, 1'b1, 1'b1, 1'b0, HI);
    check("ref_valid", dv, 1);
    check("ref_hit", cyc_hit, 0);
    check("ref_dma", cyc_dma, 0);
    check("ref_ext", de, 0);
    bus_cyc(16'hD500, 8'h02, 8'h02, 1'b1, 1'b0, 1'b1, HI);
    check("dma_valid", dv, 1);
    check("dma_hit", cyc_hit, 0);
    check("dma_flag", cyc_dma, 1);
    check("dma_ext", de, 0);

    // high phase boundary: 8 cycles is too short, 9 is enough
    win_en = 4'b0000; win_ext = 4'b0000;
    bus_cyc(16'h1111, 8'hA1, 8'hA1, 1'b1, 1'b1, 1'b1, 8);
    check("short8_valid", dv, 0);
    bus_cyc(16'h2222, 8'hA2, 8'hA2, 1'b1, 1'b1, 1'b1, 9);
    check("short9_valid", dv, 1);
    check("short9_addr", cyc_addr, 16'h2222);

    // stop the A8 clock: lost at rise + SYNC + 1 + CLK_TIMEOUT negedges
    @(negedge clk200);
    a8_addr = 16'h1234; a8_clk = 1'b1;
    k = 0; lost_prev = 1'b0;
    while (k < 400 && !clk_lost) begin
      @(negedge clk200);
      k++;
      if (k == HI) a8_clk = 1'b0;
      if (k == 257) lost_prev = clk_lost;
    end
    check("lost_time", k, 258);
    check("lost_before", lost_prev, 0);
    repeat (60) @(negedge clk200);
    check("lost_hold", clk_lost, 1);
    v0 = n_valid;
    a8_addr = 16'h4321; a8_rw_n = 1'b0; a8_clk = 1'b1;
    repeat (2) @(negedge clk200);
    check("restart_still_lost", clk_lost, 1);
    @(negedge clk200);
    check("restart_cleared", clk_lost, 0);
    repeat (HI - 3) @(negedge clk200);
    a8_clk = 1'b0;
    repeat (8) @(negedge clk200);
    check("restart_valid", n_valid - v0, 1);
    check("restart_addr", cyc_addr, 16'h4321);

    // reset during PHI2-high of a claimed read
    win_base[31:16] = 16'hD800; win_mask[31:16] = 16'hF800; win_en = 4'b0010; win_ext = 4'b0010;
    a8_addr = 16'hD805; a8_rw_n = 1'b1;
    repeat (56) @(negedge clk200);
    a8_clk = 1'b1;
    repeat (20) @(negedge clk200);
    check("mid_claim", a8_extsel_n, 0);
    v0 = n_valid;
    rst_n = 1'b0;
    #1;
    check("mid_rst_extsel", a8_extsel_n, 1);
    check("mid_rst_mpd", a8_mpd_n, 1);
    repeat (3) @(negedge clk200);
    rst_n = 1'b1;
    repeat (30) @(negedge clk200);
    a8_clk = 1'b0;
    repeat (10) @(negedge clk200);
    check("mid_no_record", n_valid - v0, 0);
    check("mid_lost", clk_lost, 1);
    check("mid_extsel_idle", a8_extsel_n, 1);
    bus_cyc(16'hD805, 8'h00, 8'h99, 1'b0, 1'b1, 1'b1, HI);
    check("post_valid", dv, 1);
    check("post_data", cyc_data, 8'h99);
    check("post_hit", cyc_hit, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/a8_bus_capture.md
# a8_bus_capture

Parametrised next-generation Atari 8-bit bus monitor for the pixl FPGA, running entirely in the clk200 domain. It synchronises the A8 bus, reconstructs each PHI2 cycle, and latches address, data and direction. It matches each cycle against NUM_WIN programmable address windows and emits one qualified cycle record per bus cycle. It also drives a8_extsel_n / a8_mpd_n per window and flags loss of the A8 clock.

## Interface
Parameters:
- NUM_WIN, 4: number of address windows (1..8).
- SYNC_STAGES, 2: synchroniser depth for all A8 inputs (2..4).
- ADDR_DLY, 8: clk200 cycles after detected PHI2 rise at which address/rw/halt/ref are sampled (1..40).
- CLK_TIMEOUT, 255: clk200 cycles without a PHI2 rise before clk_lost sets (≥ 128).

Ports:
- clk200  in  1  200 MHz system clock.
- rst_n  in  1  asynchronous, active-low reset.
- a8_clk, a8_rw_n, a8_halt_n, a8_rst_n, a8_ref_n  in  1 each  raw A8 bus signals.
- a8_addr  in  16  raw A8 address.
- a8_data  in  8  raw A8 data.
- win_base  in  16*NUM_WIN  window i base at [16i+15:16i].
- win_mask  in  16*NUM_WIN  address bits compared (1 = compare).
- win_en  in  NUM_WIN  window enable.
- win_ext  in  NUM_WIN  window claims the bus (drives extsel/mpd on reads).
- cyc_valid  out  1  one-clk200 pulse per completed A8 cycle.
- cyc_addr  out  16  captured address.
- cyc_data  out  8  captured data.
- cyc_rw_n  out  1  captured direction.
- cyc_dma  out  1  cycle had a8_halt_n low (ANTIC DMA).
- cyc_hit  out  NUM_WIN  per-window match vector.
- cyc_win  out  3  lowest-index hit; valid only when |cyc_hit.
- a8_extsel_n  out  1  low while a claimed read is in PHI2-high.
- a8_mpd_n  out  1  low while a claimed read addresses $D800-$DFFF.
- clk_lost  out  1  A8 clock absent.

## Operation
- All A8 inputs pass through SYNC_STAGES flops. phi2_rise/phi2_fall are decoded from the last two stages of synchronised a8_clk.
- FSM: IDLE → (phi2_rise) WAIT_ADDR → (counter == ADDR_DLY) HIGH → (phi2_fall) DONE → IDLE, with DONE lasting 1 cycle.
- phi2_rise in any state restarts at WAIT_ADDR and aborts the current cycle without a cyc_valid pulse.
- At the ADDR_DLY sample, latch addr, rw_n, halt_n and ref_n. Compute hit[i] = win_en[i] & (((addr ^ base_i) & mask_i) == 0).
- Hits are forced to 0 when ref_n = 0 (refresh), halt_n = 0 (DMA), or synchronised a8_rst_n = 0.
- Data capture: latch synchronised a8_data from the cycle before phi2_fall is detected, i.e. the last sample with PHI2 high. This applies to reads and writes.
- DONE: cyc_valid = 1. cyc_addr, cyc_data, cyc_rw_n, cyc_dma, cyc_hit and cyc_win update together and hold until the next DONE.
- Claim: from the ADDR_DLY sample until phi2_fall, if rw_n = 1 and hit & win_ext ≠ 0:
  - a8_extsel_n = 0;
  - additionally a8_mpd_n = 0 if addr[15:11] = 5'b11011.
  - Both outputs are registered; no combinational path from any input.
- Watchdog: an 8-bit-or-wider counter clears on phi2_rise and saturates. clk_lost = 1 when the counter reaches CLK_TIMEOUT; it clears on the next phi2_rise.
- While clk_lost = 1, the FSM is held in IDLE and extsel/mpd are released.

## Timing
- Reset values:
  - outputs: cyc_valid 0, cyc_* 0, cyc_rw_n 1, a8_extsel_n 1, a8_mpd_n 1, clk_lost 1;
  - internals: FSM in IDLE.
- Latency:
  - raw a8_clk rise → phi2_rise: SYNC_STAGES+1 clk200 cycles.
  - extsel/mpd assert 1 cycle after the ADDR_DLY sample.
  - extsel/mpd deassert 1 cycle after phi2_fall.
  - cyc_valid occurs 1 cycle after phi2_fall.
- Nominal A8 cycle ≈ 112 clk200 cycles (≈ 56 high). A PHI2-high phase shorter than ADDR_DLY+1 clk200 cycles produces no record.
- Config inputs (win_*) are sampled at the ADDR_DLY instant only. Changes mid-cycle affect the next cycle.
- Multiple hits: cyc_hit shows all hits; cyc_win gives the lowest index. Claim triggers if any hit window has win_ext set.
- rst_n asserted mid-cycle clears everything immediately. No partial record is emitted after release.

## Test plan
- Write $D500 data $5A, win0 base $D500 mask $FF00 en → one cyc_valid; addr $D500, data $5A, rw_n 0, hit 0001, win 0; extsel_n stays 1.
- Read $D805 with win1 base $D800 mask $F800 ext=1 → extsel_n and mpd_n low from ADDR_DLY+1 through fall+1; cyc_hit 0010.
- Overlapping win0/win2 both matching $C000 → cyc_hit 0101, cyc_win 0.
- Read $D500 with a8_ref_n low, then with a8_halt_n low → cyc_hit 0000 both times; extsel_n stays 1; the second record has cyc_dma 1.
- Stop a8_clk for 300 clk200 cycles → clk_lost rises at 255. Restart → clk_lost clears on the first phi2_rise; the first full cycle after restart yields a valid record.
- Assert rst_n low during PHI2-high of a claimed read → extsel_n returns to 1 asynchronously; no cyc_valid for that cycle; clk_lost 1 after release.
